// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state type and access-size helpers for the MEM-stage LSU
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;

  function automatic logic size_aligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_H, F3_HU: size_aligned = ~offset[0];
      F3_W:        size_aligned = (offset == 2'b00);
      default:     size_aligned = 1'b1;
    endcase
  endfunction

  // Stores only have B/H/W; loads additionally have the unsigned B/H forms.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: funct3_legal = 1'b1;
      F3_BU, F3_HU:     funct3_legal = ~is_store;
      default:          funct3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_B, F3_BU: byte_enables = 4'b0001 << offset;
      F3_H, F3_HU: byte_enables = 4'b0011 << offset;
      default:     byte_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] data);
    case (funct3)
      F3_B:    store_lanes = {4{data[7:0]}};
      F3_H:    store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed byte/half of a read word and sign/zero extends it
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] rd_data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    rd_data = '0;
    case (funct3)
      F3_B:  rd_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:  rd_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:  rd_data = rdata;
      F3_BU: rd_data = {24'h000000, shifted[7:0]};
      F3_HU: rd_data = {16'h0000, shifted[15:0]};
      default: rd_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: handshaked word accesses, lane handling, stall and timeout
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            funct3,
  output logic                  stall,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  err_misalign,
  output logic                  err_illegal,
  output logic                  err_timeout,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DM_ADDRESS-3:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_t state, state_next;

  logic [CNT_W-1:0]  cnt;
  logic [2:0]        funct3_q;
  logic [1:0]        offset_q;
  logic              access, is_store, legal, aligned, accept, cnt_hit;
  logic [DATA_W-1:0] load_word;

  assign access   = mem_read | mem_write;
  assign is_store = mem_write;
  assign legal    = funct3_legal(is_store, funct3);
  assign aligned  = size_aligned(funct3, addr[1:0]);
  assign accept   = access & legal & aligned;
  // Last REQ cycle allowed without an ack.
  assign cnt_hit  = (cnt == CNT_W'(TIMEOUT - 1));

  lsu_load_align u_load_align (
    .rdata  (mem_rdata),
    .offset (offset_q),
    .funct3 (funct3_q),
    .rd_data(load_word)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    mem_req    = 1'b0;
    rd_valid   = 1'b0;
    case (state)
      IDLE: begin
        stall = accept;
        if (accept) state_next = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ack || cnt_hit) state_next = DONE;
      end
      DONE: begin
        rd_valid   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      funct3_q     <= '0;
      offset_q     <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
      rd_data      <= '0;
      err_misalign <= 1'b0;
      err_illegal  <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      err_misalign <= (state == IDLE) & access & legal & ~aligned;
      err_illegal  <= (state == IDLE) & access & ~legal;
      err_timeout  <= (state == REQ) & ~mem_ack & cnt_hit;
      if (state == IDLE && accept) begin
        mem_we    <= is_store;
        mem_addr  <= addr[DM_ADDRESS-1:2];
        mem_be    <= byte_enables(funct3, addr[1:0]);
        mem_wdata <= store_lanes(funct3, wr_data);
        funct3_q  <= funct3;
        offset_q  <= addr[1:0];
        cnt       <= '0;
      end
      if (state == REQ) begin
        if (mem_ack) begin
          rd_data <= mem_we ? '0 : load_word;
        end else begin
          if (cnt != CNT_W'(TIMEOUT)) cnt <= cnt + 1'b1;
          if (cnt_hit) rd_data <= '0;
        end
      end
    end
  end

endmodule
